// File: rtl/fb_rst_seq.sv
// Staged reset sequencer for the fbclk domain: synchronised release, then NUM_STAGES resets released in order.
// Optional hold watchdog enabled by defining FB_RST_SEQ_HOLD_WDOG_EN.
//
// state  | meaning
// SYNC   | release synchroniser filling with ones; all stages held in reset
// STAGE  | releasing stages one per STAGE_GAP cycles
// RUN    | all stages released; waits for sw_rst_req

module fb_rst_seq #(
    parameter int SYNC_DEPTH   = 16,
    parameter int NUM_STAGES   = 4,
    parameter int STAGE_GAP    = 64,
    parameter int CNT_W        = 8,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                  fbclk,
    input  logic                  fbclk_rst_cause_b,
    input  logic                  sw_rst_req,
    input  logic                  hold_req,
    output logic [NUM_STAGES-1:0] rst_b,
    output logic                  seq_done,
    output logic [CNT_W-1:0]      seq_count,
    output logic [1:0]            state_o,
    output logic                  hold_timeout
);

    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_STAGE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [SYNC_DEPTH-1:0]   sync_sr, sync_sr_nxt;
    logic [GAP_W-1:0]        gap_cnt, gap_cnt_nxt;
    logic [IDX_W-1:0]        stage_idx, stage_idx_nxt;
    logic [NUM_STAGES-1:0]   rst_b_nxt;
    logic                    seq_done_nxt;
    logic [CNT_W-1:0]        seq_count_nxt;
    logic                    hold_eff;
    logic                    wdog_trip;

`ifdef FB_RST_SEQ_HOLD_WDOG_EN
    localparam int WD_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(HOLD_TIMEOUT - 1);

    logic [WD_W-1:0] wdog_cnt, wdog_cnt_nxt;
    logic            hold_timeout_nxt;

    assign wdog_trip = hold_timeout;

    // Down-counter armed while not holding; terminal count on the HOLD_TIMEOUT-th held cycle.
    always_comb begin
        wdog_cnt_nxt     = WD_LOAD;
        hold_timeout_nxt = hold_timeout;
        if (sw_rst_req) begin
            hold_timeout_nxt = 1'b0;
        end else if (state != ST_RUN && hold_req && !hold_timeout) begin
            if (wdog_cnt == '0) begin
                hold_timeout_nxt = 1'b1;
            end else begin
                wdog_cnt_nxt = wdog_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge fbclk or negedge fbclk_rst_cause_b) begin
        if (!fbclk_rst_cause_b) begin
            wdog_cnt     <= WD_LOAD;
            hold_timeout <= 1'b0;
        end else begin
            wdog_cnt     <= wdog_cnt_nxt;
            hold_timeout <= hold_timeout_nxt;
        end
    end
`else
    assign wdog_trip    = 1'b0;
    assign hold_timeout = 1'b0;
`endif

    assign hold_eff = hold_req && !wdog_trip;
    assign state_o  = state;

    always_comb begin
        state_nxt     = state;
        sync_sr_nxt   = sync_sr;
        gap_cnt_nxt   = gap_cnt;
        stage_idx_nxt = stage_idx;
        rst_b_nxt     = rst_b;
        seq_done_nxt  = seq_done;
        seq_count_nxt = seq_count;
        if (sw_rst_req) begin
            state_nxt     = ST_SYNC;
            sync_sr_nxt   = '0;
            gap_cnt_nxt   = '0;
            stage_idx_nxt = '0;
            rst_b_nxt     = '0;
            seq_done_nxt  = 1'b0;
            if (seq_count != '1) begin
                seq_count_nxt = seq_count + 1'b1;
            end
        end else begin
            case (state)
                ST_SYNC: begin
                    if (!hold_eff) begin
                        sync_sr_nxt = {sync_sr[SYNC_DEPTH-2:0], 1'b1};
                        if (sync_sr[SYNC_DEPTH-1]) begin
                            rst_b_nxt[0] = 1'b1;
                            if (NUM_STAGES == 1) begin
                                state_nxt    = ST_RUN;
                                seq_done_nxt = 1'b1;
                            end else begin
                                state_nxt = ST_STAGE;
                            end
                        end
                    end
                end
                ST_STAGE: begin
                    if (!hold_eff) begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt_nxt              = '0;
                            stage_idx_nxt            = stage_idx + 1'b1;
                            rst_b_nxt[stage_idx_nxt] = 1'b1;
                            if (stage_idx_nxt == IDX_LAST) begin
                                state_nxt    = ST_RUN;
                                seq_done_nxt = 1'b1;
                            end
                        end else begin
                            gap_cnt_nxt = gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge fbclk or negedge fbclk_rst_cause_b) begin
        if (!fbclk_rst_cause_b) begin
            state     <= ST_SYNC;
            sync_sr   <= '0;
            gap_cnt   <= '0;
            stage_idx <= '0;
            rst_b     <= '0;
            seq_done  <= 1'b0;
            seq_count <= '0;
        end else begin
            state     <= state_nxt;
            sync_sr   <= sync_sr_nxt;
            gap_cnt   <= gap_cnt_nxt;
            stage_idx <= stage_idx_nxt;
            rst_b     <= rst_b_nxt;
            seq_done  <= seq_done_nxt;
            seq_count <= seq_count_nxt;
        end
    end

endmodule

// File: tb/tb_fb_rst_seq.sv
// Directed bench for fb_rst_seq with default parameters; edge numbers are counted from the last reset event.

module tb_fb_rst_seq;

    logic       fbclk = 1'b0;
    logic       fbclk_rst_cause_b;
    logic       sw_rst_req;
    logic       hold_req;
    logic [3:0] rst_b;
    logic       seq_done;
    logic [7:0] seq_count;
    logic [1:0] state_o;
    logic       hold_timeout;

    int ec;
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    fb_rst_seq dut (
        .fbclk             (fbclk),
        .fbclk_rst_cause_b (fbclk_rst_cause_b),
        .sw_rst_req        (sw_rst_req),
        .hold_req          (hold_req),
        .rst_b             (rst_b),
        .seq_done          (seq_done),
        .seq_count         (seq_count),
        .state_o           (state_o),
        .hold_timeout      (hold_timeout)
    );

    always #5 fbclk = ~fbclk;

    task automatic tick;
        @(posedge fbclk);
        ec++;
        #1;
    endtask

    task automatic run_to(input int n);
        while (ec < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_rst, input logic e_done, input logic [1:0] e_st);
        chk({tag, ".rst_b"}, 32'(rst_b), 32'(e_rst));
        chk({tag, ".done"}, 32'(seq_done), 32'(e_done));
        chk({tag, ".state"}, 32'(state_o), 32'(e_st));
    endtask

    task automatic sw_pulse(input logic with_hold);
        sw_rst_req = 1'b1;
        hold_req   = with_hold;
        tick();
        ec = 0;
        sw_rst_req = 1'b0;
    endtask

    initial begin
        fbclk_rst_cause_b = 1'b0;
        sw_rst_req        = 1'b0;
        hold_req          = 1'b0;
        ec                = 0;
        repeat (3) tick();
        chk_all("reset", 4'b0000, 1'b0, 2'd0);
        chk("reset.count", 32'(seq_count), 0);
        chk("reset.wdog", 32'(hold_timeout), 0);

        // Plain release
        fbclk_rst_cause_b = 1'b1;
        ec = 0;
        run_to(16);  chk_all("e16", 4'b0000, 1'b0, 2'd0);
        run_to(17);  chk_all("e17", 4'b0001, 1'b0, 2'd1);
        run_to(80);  chk_all("e80", 4'b0001, 1'b0, 2'd1);
        run_to(81);  chk_all("e81", 4'b0011, 1'b0, 2'd1);
        run_to(144); chk_all("e144", 4'b0011, 1'b0, 2'd1);
        run_to(145); chk_all("e145", 4'b0111, 1'b0, 2'd1);
        run_to(208); chk_all("e208", 4'b0111, 1'b0, 2'd1);
        run_to(209); chk_all("e209", 4'b1111, 1'b1, 2'd2);
        run_to(230); chk_all("run", 4'b1111, 1'b1, 2'd2);

        // Software re-sequence from RUN
        sw_pulse(1'b0);
        chk_all("sw.e0", 4'b0000, 1'b0, 2'd0);
        chk("sw.count", 32'(seq_count), 1);
        run_to(16);  chk_all("sw.e16", 4'b0000, 1'b0, 2'd0);
        run_to(17);  chk_all("sw.e17", 4'b0001, 1'b0, 2'd1);
        run_to(208); chk_all("sw.e208", 4'b0111, 1'b0, 2'd1);
        run_to(209); chk_all("sw.e209", 4'b1111, 1'b1, 2'd2);

        // Hold during STAGE for edges 50..59
        sw_pulse(1'b0);
        chk("hold.count", 32'(seq_count), 2);
        run_to(49);
        hold_req = 1'b1;
        run_to(59);
        hold_req = 1'b0;
        chk_all("hold.e59", 4'b0001, 1'b0, 2'd1);
        chk("hold.wdog", 32'(hold_timeout), 0);
        run_to(81);  chk_all("hold.e81", 4'b0001, 1'b0, 2'd1);
        run_to(90);  chk_all("hold.e90", 4'b0001, 1'b0, 2'd1);
        run_to(91);  chk_all("hold.e91", 4'b0011, 1'b0, 2'd1);
        run_to(218); chk_all("hold.e218", 4'b0111, 1'b0, 2'd1);
        run_to(219); chk_all("hold.e219", 4'b1111, 1'b1, 2'd2);

        // Hold is ignored in RUN
        hold_req = 1'b1;
        run_to(230);
        hold_req = 1'b0;
        chk_all("hold.run", 4'b1111, 1'b1, 2'd2);

        // sw_rst_req together with hold_req: request wins, hold freezes SYNC for edges 1..5
        sw_pulse(1'b1);
        chk_all("swh.e0", 4'b0000, 1'b0, 2'd0);
        chk("swh.count", 32'(seq_count), 3);
        run_to(5);
        hold_req = 1'b0;
        run_to(21);  chk_all("swh.e21", 4'b0000, 1'b0, 2'd0);
        run_to(22);  chk_all("swh.e22", 4'b0001, 1'b0, 2'd1);

        // Restart from scratch in STAGE
        run_to(90);
        chk_all("restart.pre", 4'b0011, 1'b0, 2'd1);
        sw_pulse(1'b0);
        chk_all("restart.e0", 4'b0000, 1'b0, 2'd0);
        run_to(17);  chk_all("restart.e17", 4'b0001, 1'b0, 2'd1);

        // Async reset mid-STAGE, between clock edges
        run_to(100);
        chk_all("arst.pre", 4'b0011, 1'b0, 2'd1);
        #2;
        fbclk_rst_cause_b = 1'b0;
        #1;
        chk_all("arst.now", 4'b0000, 1'b0, 2'd0);
        chk("arst.count", 32'(seq_count), 0);
        tick();
        fbclk_rst_cause_b = 1'b1;
        ec = 0;
        run_to(16);  chk_all("arst.e16", 4'b0000, 1'b0, 2'd0);
        run_to(17);  chk_all("arst.e17", 4'b0001, 1'b0, 2'd1);
        run_to(209); chk_all("arst.e209", 4'b1111, 1'b1, 2'd2);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            sw_pulse(1'b0);
            if (i == 253) chk("sat.254", 32'(seq_count), 254);
            tick();
        end
        chk("sat.255", 32'(seq_count), 255);
        chk_all("sat.state", 4'b0000, 1'b0, 2'd0);
        chk("sat.wdog", 32'(hold_timeout), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
